// File: rtl/register_file_if.sv
// Bus bundle for register_file: one write port and two independent read ports.
interface register_file_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) ();
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic              rvalid_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              rvalid_b;

    modport master (
        output we, waddr, wdata,
        output re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b
    );

    modport slave (
        input  we, waddr, wdata,
        input  re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b
    );
endinterface

// File: rtl/register_file.sv
// 1W/2R register file with registered read data and per-port valid strobes.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a colliding read.
module register_file #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_rvalid_a;
    logic             r_rvalid_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Read source selection; bypass returns the incoming write on an address match.
`ifdef REGFILE_BYPASS_EN
    assign w_rd_a = (bus.we && (bus.waddr == bus.raddr_a)) ? bus.wdata : r_mem[bus.raddr_a];
    assign w_rd_b = (bus.we && (bus.waddr == bus.raddr_b)) ? bus.wdata : r_mem[bus.raddr_b];
`else
    assign w_rd_a = r_mem[bus.raddr_a];
    assign w_rd_b = r_mem[bus.raddr_b];
`endif

    // Storage array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem <= '{default: '0};
        end else if (bus.we) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
    end

    // Port A: data holds when idle, valid tracks the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata_a  <= '0;
            r_rvalid_a <= 1'b0;
        end else begin
            r_rvalid_a <= bus.re_a;
            if (bus.re_a) begin
                r_rdata_a <= w_rd_a;
            end
        end
    end

    // Port B mirrors port A
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata_b  <= '0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_b <= bus.re_b;
            if (bus.re_b) begin
                r_rdata_b <= w_rd_b;
            end
        end
    end

    assign bus.rdata_a  = r_rdata_a;
    assign bus.rvalid_a = r_rvalid_a;
    assign bus.rdata_b  = r_rdata_b;
    assign bus.rvalid_b = r_rvalid_b;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_register_file;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;

    register_file_if #(.WIDTH(8), .ADDR_W(3)) bus ();

    register_file #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain array plus expected read-port outputs
    logic [7:0] m_mem [8];
    logic [7:0] m_rd_a, m_rd_b;
    logic       m_rv_a, m_rv_b;

    function automatic logic [7:0] model_read(input logic [2:0] a);
        if (BYP && bus.we && bus.waddr == a) return bus.wdata;
        return m_mem[a];
    endfunction

    always @(negedge reset) begin
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_rd_a = 8'h00; m_rd_b = 8'h00; m_rv_a = 1'b0; m_rv_b = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_rv_a = bus.re_a;
            m_rv_b = bus.re_b;
            if (bus.re_a) m_rd_a = model_read(bus.raddr_a);
            if (bus.re_b) m_rd_b = model_read(bus.raddr_b);
            if (bus.we) m_mem[bus.waddr] = bus.wdata;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model rdata_a",  bus.rdata_a, m_rd_a);
            chk("model rvalid_a", 8'(bus.rvalid_a), 8'(m_rv_a));
            chk("model rdata_b",  bus.rdata_b, m_rd_b);
            chk("model rvalid_b", 8'(bus.rvalid_b), 8'(m_rv_b));
        end
    end

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic rea, input logic [2:0] ra,
                         input logic reb, input logic [2:0] rb);
        @(negedge clk);
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.re_a = rea; bus.raddr_a = ra;
        bus.re_b = reb; bus.raddr_b = rb;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    // Reads every entry on both ports back-to-back and expects all zero
    task automatic read_all_zero(input string nm);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
            else       idle();
            if (i > 0) begin
                chk({nm, " rdata_a"}, bus.rdata_a, 8'h00);
                chk({nm, " rdata_b"}, bus.rdata_b, 8'h00);
                chk({nm, " rvalid_a"}, 8'(bus.rvalid_a), 8'h01);
            end
        end
    endtask

    initial begin
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.re_a = 1'b0; bus.raddr_a = '0; bus.re_b = 1'b0; bus.raddr_b = '0;

        // Reset held for two cycles with a write and reads presented
        #2 reset = 1'b0;
        chk_on = 1'b1;
        drive(1'b1, 3'd4, 8'h77, 1'b1, 3'd4, 1'b1, 3'd4);
        @(negedge clk);
        chk("reset rvalid_a", 8'(bus.rvalid_a), 8'h00);
        chk("reset rvalid_b", 8'(bus.rvalid_b), 8'h00);
        chk("reset rdata_a",  bus.rdata_a, 8'h00);
        reset = 1'b1;
        bus.we = 1'b0; bus.re_a = 1'b0; bus.re_b = 1'b0;
        read_all_zero("post-reset");

        // Write then read
        drive(1'b1, 3'd2, 8'hAA, 1'b0, 3'd0, 1'b0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0);
        idle();
        chk("wr-rd rdata_a",  bus.rdata_a, 8'hAA);
        chk("wr-rd rvalid_a", 8'(bus.rvalid_a), 8'h01);
        idle();
        chk("idle rvalid_a", 8'(bus.rvalid_a), 8'h00);
        chk("idle rdata_a hold", bus.rdata_a, 8'hAA);

        // Write-enable gating
        drive(1'b0, 3'd2, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd2);
        idle();
        chk("we gating rdata_b", bus.rdata_b, 8'hAA);

        // Same-cycle collision
        drive(1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
        drive(1'b1, 3'd5, 8'hCC, 1'b1, 3'd5, 1'b1, 3'd6);
        idle();
        chk("collision rdata_a", bus.rdata_a, BYP ? 8'hCC : 8'h11);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0);
        idle();
        chk("after collision rdata_a", bus.rdata_a, 8'hCC);

        // Dual port, distinct then shared address
        drive(1'b1, 3'd1, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
        drive(1'b1, 3'd7, 8'hC3, 1'b0, 3'd0, 1'b0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd7);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd1);
        chk("dual rdata_a", bus.rdata_a, 8'h3C);
        chk("dual rdata_b", bus.rdata_b, 8'hC3);
        idle();
        chk("shared rdata_a", bus.rdata_a, 8'h3C);
        chk("shared rdata_b", bus.rdata_b, 8'h3C);

        // Random traffic, checked by the compare process
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 3'($urandom));
        end

        // Mid-stream asynchronous reset
        drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 1'b0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd1);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
        @(posedge clk);
        #1;
        chk("stream rdata_a", bus.rdata_a, 8'h5A);
        chk("stream rvalid_a", 8'(bus.rvalid_a), 8'h01);
        #1 reset = 1'b0;
        #1;
        chk("async rst rvalid_a", 8'(bus.rvalid_a), 8'h00);
        chk("async rst rdata_a",  bus.rdata_a, 8'h00);
        chk("async rst rvalid_b", 8'(bus.rvalid_b), 8'h00);
        chk("async rst rdata_b",  bus.rdata_b, 8'h00);
        drive(1'b1, 3'd3, 8'hFF, 1'b1, 3'd3, 1'b1, 3'd3);
        @(negedge clk);
        reset = 1'b1;
        bus.we = 1'b0; bus.re_a = 1'b0; bus.re_b = 1'b0;
        read_all_zero("after mid reset");

        repeat (2) idle();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data width of each register entry.
REQ-002 The block SHALL take parameter ADDR_W, default 3, as the address width; entry count DEPTH = 2**ADDR_W (8).
REQ-003 The block SHALL have port clk, input, 1, as the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, as the asynchronous, active-low reset.
REQ-005 The block SHALL have port we, input, 1, as write enable.
REQ-006 The block SHALL have port waddr, input, ADDR_W, as the write address.
REQ-007 The block SHALL have port wdata, input, WIDTH, as the write data.
REQ-008 The block SHALL have port re_a, input, 1, as the port-A read request.
REQ-009 The block SHALL have port raddr_a, input, ADDR_W, as the port-A read address.
REQ-010 The block SHALL have port rdata_a, output, WIDTH, as the registered port-A read data.
REQ-011 The block SHALL have port rvalid_a, output, 1, as the port-A read-data-valid strobe.
REQ-012 The block SHALL have ports re_b, raddr_b, rdata_b and rvalid_b, identical in direction, width and meaning to port A.

Function
REQ-013 The block SHALL write wdata into entry waddr on a rising edge of clk when we=1.
REQ-014 The block SHALL leave every entry unchanged when we=0, whatever the value of wdata.
REQ-015 The block SHALL, on a rising edge where re_a=1, load rdata_a with entry raddr_a and set rvalid_a=1; read latency SHALL be exactly 1 cycle.
REQ-016 The block SHALL clear rvalid_a on a rising edge where re_a=0, and rdata_a SHALL hold its last value.
REQ-017 Port B SHALL behave as REQ-015 and REQ-016, independently of port A.
REQ-018 Both read ports SHALL be allowed to read the same address in the same cycle, and both SHALL return identical data.
REQ-019 A simultaneous write and read of the same address in one cycle SHALL return data as defined in REQ-023 and REQ-024.
REQ-020 Reads of addresses other than waddr SHALL be unaffected by a write in the same cycle.
REQ-021 Back-to-back reads with re held at 1 SHALL produce one new result per cycle, with rvalid held high continuously.

Reset
REQ-022 The block SHALL, while reset=0 and without waiting for a clock edge, set all entries, rdata_a and rdata_b to 0, and rvalid_a and rvalid_b to 0; writes and reads presented while reset=0 SHALL be discarded, and normal operation SHALL resume on the first rising edge after reset returns to 1.

Configuration
REQ-023 When the macro REGFILE_BYPASS_EN is defined, the block SHALL return wdata (the new value) on a read port whose raddr equals waddr in a cycle where we=1 and re=1.
REQ-024 When REGFILE_BYPASS_EN is not defined, the block SHALL return the entry's previous contents in that case, and the new value SHALL be visible from the next read onward.

Verification
REQ-025 The bench SHALL cover reset check: hold reset=0 for 2 cycles then release, and read all 8 addresses -> every rdata=0x00; rvalid=0 during reset.
REQ-026 The bench SHALL cover write then read: write 0xAA to addr 2, then re_a=1 with raddr_a=2 on the next cycle -> rdata_a=0xAA and rvalid_a=1 one cycle later.
REQ-027 The bench SHALL cover write-enable gating: set we=0 with wdata=0xFF and waddr=2, then read addr 2 -> rdata=0xAA is retained.
REQ-028 The bench SHALL cover same-cycle collision: entry 5 holds 0x11, then we=1, waddr=5, wdata=0xCC with re_a=1, raddr_a=5 -> rdata_a=0xCC with REGFILE_BYPASS_EN defined and 0x11 without it; a following read returns 0xCC in both builds.
REQ-029 The bench SHALL cover dual port: addr 1 holds 0x3C and addr 7 holds 0xC3, read by A and B in the same cycle -> rdata_a=0x3C and rdata_b=0xC3; then both read addr 1 -> both return 0x3C.
REQ-030 The bench SHALL cover mid-operation reset: assert reset=0 asynchronously between clock edges during a streaming read -> rvalid and rdata drop to 0 immediately, and every entry reads 0x00 after release.
